// File: rtl/microcode_pkg.sv
// Shared encodings and the default microcode image (standard MIPS multicycle flow)
// for the microprogrammed sequencer.
package microcode_pkg;

  typedef enum logic [1:0] {
    AC_FETCH = 2'b00,
    AC_DISP1 = 2'b01,
    AC_DISP2 = 2'b10,
    AC_SEQ   = 2'b11
  } addrctl_e;

  typedef enum logic [1:0] {
    PS_STORE = 2'b00,
    PS_DISP1 = 2'b01,
    PS_DISP2 = 2'b10,
    PS_RSVD  = 2'b11
  } progsel_e;

  localparam int unsigned FETCH   = 0;
  localparam int unsigned DECODE  = 1;
  localparam int unsigned MEMADR  = 2;
  localparam int unsigned MEMRD   = 3;
  localparam int unsigned MEMWB   = 4;
  localparam int unsigned MEMWR   = 5;
  localparam int unsigned RTYPEEX = 6;
  localparam int unsigned RTYPEWB = 7;
  localparam int unsigned BEQEX   = 8;
  localparam int unsigned JEX     = 9;

  // ctrl bit order, MSB first: pcwrite, branch, iord, memwrite, irwrite, memtoreg,
  // regwrite, alusrca, alusrcb[1:0], pcsrc[1:0], aluop[1:0], regdst
  function automatic logic [14:0] default_ctrl(input int unsigned a);
    logic [14:0] c;
    case (a)
      FETCH:   c = 15'h4420;
      DECODE:  c = 15'h0060;
      MEMADR:  c = 15'h00C0;
      MEMRD:   c = 15'h1000;
      MEMWB:   c = 15'h0300;
      MEMWR:   c = 15'h1800;
      RTYPEEX: c = 15'h0084;
      RTYPEWB: c = 15'h0101;
      BEQEX:   c = 15'h208A;
      JEX:     c = 15'h4010;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic addrctl_e default_ac(input int unsigned a);
    addrctl_e ac;
    case (a)
      FETCH, MEMRD, RTYPEEX: ac = AC_SEQ;
      DECODE:                ac = AC_DISP1;
      MEMADR:                ac = AC_DISP2;
      default:               ac = AC_FETCH;
    endcase
    return ac;
  endfunction

  // Returns {valid, uaddr[3:0]}
  function automatic logic [4:0] default_disp(input bit second, input int unsigned op);
    logic [4:0] e;
    e = '0;
    if (!second) begin
      case (op)
        'h00:       e = {1'b1, 4'(RTYPEEX)};
        'h23, 'h2B: e = {1'b1, 4'(MEMADR)};
        'h04:       e = {1'b1, 4'(BEQEX)};
        'h02:       e = {1'b1, 4'(JEX)};
        default:    e = '0;
      endcase
    end else begin
      case (op)
        'h23:    e = {1'b1, 4'(MEMRD)};
        'h2B:    e = {1'b1, 4'(MEMWR)};
        default: e = '0;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/microcode_sequencer_dispatch.sv
// Opcode dispatch table: writable register array, synchronous write, combinational read.
// Contents power up from the package default image and are never reset.
module dispatch_table
  import microcode_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned UADDR_W  = 4,
  parameter bit          SECOND   = 1'b0
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [OPCODE_W-1:0] waddr_i,
  input  logic [UADDR_W:0]    wdata_i,
  input  logic [OPCODE_W-1:0] raddr_i,
  output logic                valid_o,
  output logic [UADDR_W-1:0]  uaddr_o
);

  localparam int unsigned DEPTH = 2 ** OPCODE_W;

  typedef logic [UADDR_W:0] entry_t;
  typedef entry_t image_t [DEPTH];

  function automatic image_t default_image();
    image_t     img;
    logic [4:0] e;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      e      = default_disp(SECOND, i);
      img[i] = {e[4], UADDR_W'(e[3:0])};
    end
    return img;
  endfunction

  image_t mem_q = default_image();

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign {valid_o, uaddr_o} = mem_q[raddr_i];

endmodule

// File: rtl/microcode_sequencer.sv
// Microprogrammed control unit: registered micro-PC into a writable control store,
// with fetch / two-level opcode dispatch / sequential next-address selection.
module microcode_sequencer
  import microcode_pkg::*;
#(
  parameter int unsigned UADDR_W   = 4,
  parameter int unsigned CTRL_W    = 15,
  parameter int unsigned OPCODE_W  = 6,
  parameter int unsigned TRAP_ADDR = 15,
  localparam int unsigned PA_W     = (UADDR_W > OPCODE_W) ? UADDR_W : OPCODE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                prog_we,
  input  logic [1:0]          prog_sel,
  input  logic [PA_W-1:0]     prog_addr,
  input  logic [CTRL_W+1:0]   prog_data,
  output logic [CTRL_W-1:0]   ctrl,
  output logic [UADDR_W-1:0]  upc,
  output logic                uerror
);

  localparam int unsigned DEPTH = 2 ** UADDR_W;

  typedef logic [CTRL_W+1:0] word_t;
  typedef word_t store_t [DEPTH];

  function automatic store_t default_store();
    store_t img;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      img[i] = {CTRL_W'(default_ctrl(i)), default_ac(i)};
    end
    return img;
  endfunction

  store_t               store_q = default_store();
  logic [UADDR_W-1:0]   upc_q, upc_d;
  logic                 uerr_q, uerr_d;
  word_t                word_cur;
  addrctl_e             ac;
  progsel_e             sel;
  logic                 store_we, d1_we, d2_we;
  logic                 d1_valid, d2_valid;
  logic [UADDR_W-1:0]   d1_uaddr, d2_uaddr;

  assign sel      = progsel_e'(prog_sel);
  assign store_we = prog_we && (sel == PS_STORE);
  assign d1_we    = prog_we && (sel == PS_DISP1);
  assign d2_we    = prog_we && (sel == PS_DISP2);

  dispatch_table #(
    .OPCODE_W (OPCODE_W),
    .UADDR_W  (UADDR_W),
    .SECOND   (1'b0)
  ) u_disp1 (
    .clk_i   (clk),
    .we_i    (d1_we),
    .waddr_i (prog_addr[OPCODE_W-1:0]),
    .wdata_i (prog_data[UADDR_W:0]),
    .raddr_i (opcode),
    .valid_o (d1_valid),
    .uaddr_o (d1_uaddr)
  );

  dispatch_table #(
    .OPCODE_W (OPCODE_W),
    .UADDR_W  (UADDR_W),
    .SECOND   (1'b1)
  ) u_disp2 (
    .clk_i   (clk),
    .we_i    (d2_we),
    .waddr_i (prog_addr[OPCODE_W-1:0]),
    .wdata_i (prog_data[UADDR_W:0]),
    .raddr_i (opcode),
    .valid_o (d2_valid),
    .uaddr_o (d2_uaddr)
  );

  // Store is deliberately outside the reset domain so loaded microcode survives reset.
  always_ff @(posedge clk) begin
    if (store_we) store_q[prog_addr[UADDR_W-1:0]] <= prog_data;
  end

  assign word_cur = store_q[upc_q];
  assign ac       = addrctl_e'(word_cur[1:0]);

  always_comb begin
    upc_d  = upc_q;
    uerr_d = uerr_q;
    if (!stall) begin
      case (ac)
        AC_FETCH: upc_d = '0;
        AC_DISP1: begin
          if (d1_valid) begin
            upc_d = d1_uaddr;
          end else begin
            upc_d  = UADDR_W'(TRAP_ADDR);
            uerr_d = 1'b1;
          end
        end
        AC_DISP2: begin
          if (d2_valid) begin
            upc_d = d2_uaddr;
          end else begin
            upc_d  = UADDR_W'(TRAP_ADDR);
            uerr_d = 1'b1;
          end
        end
        AC_SEQ:   upc_d = upc_q + 1'b1;
        default:  upc_d = upc_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc_q  <= '0;
      uerr_q <= 1'b0;
    end else begin
      upc_q  <= upc_d;
      uerr_q <= uerr_d;
    end
  end

  assign ctrl   = word_cur[CTRL_W+1:2];
  assign upc    = upc_q;
  assign uerror = uerr_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: default MIPS flows, trap, stall,
// runtime programming, read-during-write, wrap and async reset.
module tb_microcode_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, prog_we;
  logic [5:0]  opcode, prog_addr;
  logic [1:0]  prog_sel;
  logic [16:0] prog_data;
  logic [14:0] ctrl;
  logic [3:0]  upc;
  logic        uerror;

  int vectors     = 0;
  int miscompares = 0;

  microcode_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .opcode    (opcode),
    .prog_we   (prog_we),
    .prog_sel  (prog_sel),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .ctrl      (ctrl),
    .upc       (upc),
    .uerror    (uerror)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [3:0] exp_upc);
    tick();
    chk(tag, 32'(upc), 32'(exp_upc));
  endtask

  task automatic prog(input logic [1:0] sel, input logic [5:0] addr, input logic [16:0] data);
    prog_we   = 1'b1;
    prog_sel  = sel;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; prog_we = 1'b0;
    prog_sel = 2'b00; prog_addr = '0; prog_data = '0; opcode = 6'h23;
    #12 reset = 1'b0;
    #1;
    chk("rst_upc", 32'(upc), 32'd0);
    chk("rst_uerr", 32'(uerror), 32'd0);
    chk("fetch_ctrl", 32'(ctrl), 32'h4420);

    // lw
    step("lw_1", 4'd1); chk("decode_ctrl", 32'(ctrl), 32'h0060);
    step("lw_2", 4'd2); chk("memadr_ctrl", 32'(ctrl), 32'h00C0);
    step("lw_3", 4'd3); chk("memrd_ctrl", 32'(ctrl), 32'h1000);
    step("lw_4", 4'd4); chk("memwb_ctrl", 32'(ctrl), 32'h0300);
    step("lw_0", 4'd0);

    // sw
    opcode = 6'h2B;
    step("sw_1", 4'd1); step("sw_2", 4'd2);
    step("sw_5", 4'd5); chk("memwr_ctrl", 32'(ctrl), 32'h1800);
    step("sw_0", 4'd0);

    // beq
    opcode = 6'h04;
    step("beq_1", 4'd1); step("beq_8", 4'd8); chk("beqex_ctrl", 32'(ctrl), 32'h208A);
    step("beq_0", 4'd0);

    // j
    opcode = 6'h02;
    step("j_1", 4'd1); step("j_9", 4'd9); chk("jex_ctrl", 32'(ctrl), 32'h4010);
    step("j_0", 4'd0);

    // R-type
    opcode = 6'h00;
    step("r_1", 4'd1); step("r_6", 4'd6); chk("rtypeex_ctrl", 32'(ctrl), 32'h0084);
    step("r_7", 4'd7); chk("rtypewb_ctrl", 32'(ctrl), 32'h0101);
    step("r_0", 4'd0);

    // stall at MEMADR; an invalid opcode during the stall must be ignored
    opcode = 6'h23;
    step("st_1", 4'd1); step("st_2", 4'd2);
    stall = 1'b1; opcode = 6'h3F;
    repeat (3) begin
      tick();
      chk("stall_upc", 32'(upc), 32'd2);
      chk("stall_ctrl", 32'(ctrl), 32'h00C0);
      chk("stall_uerr", 32'(uerror), 32'd0);
    end
    opcode = 6'h23; stall = 1'b0;
    step("st_3", 4'd3); step("st_4", 4'd4); step("st_0", 4'd0);

    // program a new flow: store[10] and disp1[0x08] -> 10
    stall = 1'b1;
    prog(2'b00, 6'd10, {15'h1234, 2'b11});
    prog(2'b01, 6'h08, 17'h0001A);
    chk("prog_stall_upc", 32'(upc), 32'd0);
    stall = 1'b0; opcode = 6'h08;
    step("pg_1", 4'd1);
    step("pg_10", 4'd10); chk("pg_ctrl10", 32'(ctrl), 32'h1234);
    step("pg_11", 4'd11); chk("pg_ctrl11", 32'(ctrl), 32'h0000);
    step("pg_0", 4'd0);

    // store read-during-write at upc
    stall = 1'b1;
    prog_we = 1'b1; prog_sel = 2'b00; prog_addr = 6'd0; prog_data = {15'h7ABC, 2'b11};
    chk("rdw_old", 32'(ctrl), 32'h4420);
    tick();
    prog_we = 1'b0;
    chk("rdw_new", 32'(ctrl), 32'h7ABC);
    prog(2'b00, 6'd0, {15'h4420, 2'b11});
    chk("rdw_restore", 32'(ctrl), 32'h4420);
    stall = 1'b0;

    // table written in the same cycle it is dispatched through uses the old entry
    opcode = 6'h23;
    step("tw_1", 4'd1);
    prog_we = 1'b1; prog_sel = 2'b01; prog_addr = 6'h23; prog_data = 17'h0001A;
    step("tw_old", 4'd2);
    prog(2'b01, 6'h23, 17'h00012);
    chk("tw_3", 32'(upc), 32'd3);
    step("tw_4", 4'd4); step("tw_0", 4'd0);

    // wrap 15 -> 0 via SEQ
    stall = 1'b1;
    prog(2'b00, 6'd15, {15'h0055, 2'b11});
    prog(2'b01, 6'h10, 17'h0001F);
    stall = 1'b0; opcode = 6'h10;
    step("wr_1", 4'd1);
    step("wr_15", 4'd15); chk("wr_ctrl15", 32'(ctrl), 32'h0055);
    step("wr_0", 4'd0); chk("wr_uerr", 32'(uerror), 32'd0);

    // reserved prog_sel writes nothing
    stall = 1'b1;
    prog(2'b11, 6'h23, 17'h1FFFF);
    chk("rsv_ctrl0", 32'(ctrl), 32'h4420);
    stall = 1'b0; opcode = 6'h23;
    step("rsv_1", 4'd1); step("rsv_2", 4'd2);
    step("rsv_3", 4'd3); chk("rsv_ctrl3", 32'(ctrl), 32'h1000);
    step("rsv_4", 4'd4); step("rsv_0", 4'd0);

    // illegal opcode trap, sticky uerror, async reset mid-cycle
    opcode = 6'h3F;
    step("tr_1", 4'd1); chk("tr_uerr_pre", 32'(uerror), 32'd0);
    step("tr_15", 4'd15); chk("tr_uerr", 32'(uerror), 32'd1);
    step("tr_0", 4'd0); chk("tr_sticky0", 32'(uerror), 32'd1);
    step("tr_1b", 4'd1); chk("tr_sticky1", 32'(uerror), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_upc", 32'(upc), 32'd0);
    chk("arst_uerr", 32'(uerror), 32'd0);
    #1 reset = 1'b0;
    opcode = 6'h10;
    step("kept_1", 4'd1);
    step("kept_15", 4'd15); chk("kept_ctrl15", 32'(ctrl), 32'h0055);
    step("kept_0", 4'd0); chk("kept_uerr", 32'(uerror), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
